// File: rtl/mc_controller.sv
// Multicycle sequencing controller for the MIPS core: one Moore state per step,
// driving the shared memory port, IR/PC enables, ALU muxes, register writes and the MULTU wait.
module mc_controller #(
    parameter int MUL_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic       iord,
    output logic       ir_we,
    output logic       we_dm,
    output logic       reg_dst,
    output logic       dm2reg,
    output logic       we_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       jal,
    output logic       jr,
    output logic       mul_start,
    output logic       mul_busy,
    output logic       mf_hi_lo,
    output logic       hi_lo,
    output logic       retire,
    output logic       illegal,
    output logic [4:0] state
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [4:0] S_RESET    = 5'd0;
    localparam logic [4:0] S_FETCH    = 5'd1;
    localparam logic [4:0] S_DECODE   = 5'd2;
    localparam logic [4:0] S_MEMADR   = 5'd3;
    localparam logic [4:0] S_MEMRD    = 5'd4;
    localparam logic [4:0] S_MEMWB    = 5'd5;
    localparam logic [4:0] S_MEMWR    = 5'd6;
    localparam logic [4:0] S_EXEC     = 5'd7;
    localparam logic [4:0] S_ALUWB    = 5'd8;
    localparam logic [4:0] S_BRANCH   = 5'd9;
    localparam logic [4:0] S_ADDIEX   = 5'd10;
    localparam logic [4:0] S_ADDIWB   = 5'd11;
    localparam logic [4:0] S_JUMP     = 5'd12;
    localparam logic [4:0] S_JAL      = 5'd13;
    localparam logic [4:0] S_JR       = 5'd14;
    localparam logic [4:0] S_MULSTART = 5'd15;
    localparam logic [4:0] S_MULWAIT  = 5'd16;
    localparam logic [4:0] S_MFHL     = 5'd17;
    localparam logic [4:0] S_ILLEGAL  = 5'd18;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [4:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; opcode/funct are held stable from DECODE to the final step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    OP_RTYPE: begin
                        case (funct)
                            F_JR:                           state_d = S_JR;
                            F_MULTU:                        state_d = S_MULSTART;
                            F_MFHI, F_MFLO:                 state_d = S_MFHL;
                            F_ADD, F_SUB, F_AND, F_OR, F_SLT: state_d = S_EXEC;
                            default:                        state_d = S_ILLEGAL;
                        endcase
                    end
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = S_FETCH;
            S_EXEC:     state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEX:   state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_JAL:      state_d = S_FETCH;
            S_JR:       state_d = S_FETCH;
            S_MULSTART: begin
                cnt_d   = CW'(MUL_CYCLES - 1);
                state_d = S_MULWAIT;
            end
            S_MULWAIT: begin
                // The counter counts down to zero, giving exactly MUL_CYCLES wait cycles.
                if (cnt_q == '0) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_MFHL:     state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_RESET;
        endcase
    end

    always_comb begin
        pc_we     = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        we_dm     = 1'b0;
        reg_dst   = 1'b0;
        dm2reg    = 1'b0;
        we_reg    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_ctrl  = 3'b000;
        pc_src    = 2'b00;
        jal       = 1'b0;
        jr        = 1'b0;
        mul_start = 1'b0;
        mul_busy  = 1'b0;
        mf_hi_lo  = 1'b0;
        hi_lo     = 1'b0;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                dm2reg = 1'b1;
                we_reg = 1'b1;
                retire = 1'b1;
            end
            S_MEMWR: begin
                iord   = 1'b1;
                we_dm  = 1'b1;
                retire = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    F_SUB:   alu_ctrl = ALU_SUB;
                    F_AND:   alu_ctrl = ALU_AND;
                    F_OR:    alu_ctrl = ALU_OR;
                    F_SLT:   alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                reg_dst = 1'b1;
                we_reg  = 1'b1;
                retire  = 1'b1;
            end
            S_BRANCH: begin
                // The only non-Moore output: PC is loaded from ALUOut only when taken.
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_we     = zero;
                retire    = 1'b1;
            end
            S_ADDIWB: begin
                we_reg = 1'b1;
                retire = 1'b1;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            S_JAL: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
                jal    = 1'b1;
                we_reg = 1'b1;
                retire = 1'b1;
            end
            S_JR: begin
                pc_src = 2'b11;
                pc_we  = 1'b1;
                jr     = 1'b1;
                retire = 1'b1;
            end
            S_MULSTART: mul_start = 1'b1;
            S_MULWAIT: begin
                mul_busy = 1'b1;
                retire   = (cnt_q == '0);
            end
            S_MFHL: begin
                mf_hi_lo = 1'b1;
                hi_lo    = (funct == F_MFHI);
                reg_dst  = 1'b1;
                we_reg   = 1'b1;
                retire   = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each instruction expands into its list of steps,
// and every step's full output vector is compared against the DUT on the falling edge.
module tb_mc_controller;

    localparam int MULC = 4;

    localparam int S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4;
    localparam int S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_ALUWB = 8, S_BRANCH = 9;
    localparam int S_ADDIEX = 10, S_ADDIWB = 11, S_JUMP = 12, S_JAL = 13, S_JR = 14;
    localparam int S_MULSTART = 15, S_MULWAIT = 16, S_MFHL = 17, S_ILLEGAL = 18;

    typedef struct packed {
        logic       pc_we, iord, ir_we, we_dm, reg_dst, dm2reg, we_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       jal, jr, mul_start, mul_busy, mf_hi_lo, hi_lo, retire, illegal;
        logic [4:0] state;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pc_we, iord, ir_we, we_dm, reg_dst, dm2reg, we_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic       jal, jr, mul_start, mul_busy, mf_hi_lo, hi_lo, retire, illegal;
    logic [4:0] state;

    mc_controller #(.MUL_CYCLES(MULC)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_we(pc_we), .iord(iord), .ir_we(ir_we), .we_dm(we_dm),
        .reg_dst(reg_dst), .dm2reg(dm2reg), .we_reg(we_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .jal(jal), .jr(jr), .mul_start(mul_start),
        .mul_busy(mul_busy), .mf_hi_lo(mf_hi_lo), .hi_lo(hi_lo),
        .retire(retire), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    ov_t dut_ov;
    assign dut_ov = {pc_we, iord, ir_we, we_dm, reg_dst, dm2reg, we_reg, alu_src_a,
                     alu_src_b, alu_ctrl, pc_src, jal, jr, mul_start, mul_busy,
                     mf_hi_lo, hi_lo, retire, illegal, state};

    int  checks = 0;
    int  errors = 0;
    ov_t exp_q[$];
    int  lat_cnt = 0;
    int  last_lat = 0;
    int  retire_cnt = 0;

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Output set required in each named step of an instruction.
    function automatic ov_t rec(input int s, input logic [5:0] fn, input logic z, input logic last);
        ov_t o;
        o = '0;
        o.state = 5'(s);
        case (s)
            S_FETCH:    begin o.ir_we = 1; o.pc_we = 1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010; end
            S_DECODE:   begin o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; end
            S_MEMADR,
            S_ADDIEX:   begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
            S_MEMRD:    o.iord = 1;
            S_MEMWB:    begin o.dm2reg = 1; o.we_reg = 1; o.retire = 1; end
            S_MEMWR:    begin o.iord = 1; o.we_dm = 1; o.retire = 1; end
            S_EXEC:     begin o.alu_src_a = 1; o.alu_ctrl = alu_of(fn); end
            S_ALUWB:    begin o.reg_dst = 1; o.we_reg = 1; o.retire = 1; end
            S_BRANCH:   begin o.alu_src_a = 1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01; o.pc_we = z; o.retire = 1; end
            S_ADDIWB:   begin o.we_reg = 1; o.retire = 1; end
            S_JUMP:     begin o.pc_src = 2'b10; o.pc_we = 1; o.retire = 1; end
            S_JAL:      begin o.pc_src = 2'b10; o.pc_we = 1; o.jal = 1; o.we_reg = 1; o.retire = 1; end
            S_JR:       begin o.pc_src = 2'b11; o.pc_we = 1; o.jr = 1; o.retire = 1; end
            S_MULSTART: o.mul_start = 1;
            S_MULWAIT:  begin o.mul_busy = 1; o.retire = last; end
            S_MFHL:     begin o.mf_hi_lo = 1; o.hi_lo = (fn == 6'b010000); o.reg_dst = 1; o.we_reg = 1; o.retire = 1; end
            S_ILLEGAL:  o.illegal = 1;
            default: ;
        endcase
        return o;
    endfunction

    // Compare process: one expected vector per falling edge while any are queued.
    initial begin
        ov_t e;
        forever begin
            @(negedge clk);
            if (int'(state) == S_FETCH) lat_cnt = 1;
            else lat_cnt = lat_cnt + 1;
            if (retire) begin
                last_lat = lat_cnt;
                retire_cnt = retire_cnt + 1;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks = checks + 1;
                if (dut_ov !== e) begin
                    errors = errors + 1;
                    $display("FAIL outputs step=%0d got=%h want=%h", e.state, dut_ov, e);
                end else begin
                    $display("ok step=%0d outputs=%h", e.state, dut_ov);
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end else begin
            $display("ok %s = %0d", nm, got);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        errors = errors + 1;
        $display("FAIL drain_timeout got=%0d_pending want=0", exp_q.size());
        exp_q.delete();
    endtask

    // Expands one instruction into its step list, queues the expected vectors, waits for completion.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input bit with_reset, input int n_ill);
        int sq[$];
        opcode = op;
        funct  = fn;
        zero   = z;
        if (with_reset) sq.push_back(S_RESET);
        sq.push_back(S_FETCH);
        sq.push_back(S_DECODE);
        case (op)
            6'b100011: begin sq.push_back(S_MEMADR); sq.push_back(S_MEMRD); sq.push_back(S_MEMWB); end
            6'b101011: begin sq.push_back(S_MEMADR); sq.push_back(S_MEMWR); end
            6'b000100: sq.push_back(S_BRANCH);
            6'b001000: begin sq.push_back(S_ADDIEX); sq.push_back(S_ADDIWB); end
            6'b000010: sq.push_back(S_JUMP);
            6'b000011: sq.push_back(S_JAL);
            6'b000000: begin
                if (fn == 6'b001000) sq.push_back(S_JR);
                else if (fn == 6'b011001) begin
                    sq.push_back(S_MULSTART);
                    for (int k = 0; k < MULC; k++) sq.push_back(S_MULWAIT);
                end else if (fn == 6'b010000 || fn == 6'b010010) sq.push_back(S_MFHL);
                else if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                         fn == 6'b100101 || fn == 6'b101010) begin
                    sq.push_back(S_EXEC); sq.push_back(S_ALUWB);
                end else for (int k = 0; k < n_ill; k++) sq.push_back(S_ILLEGAL);
            end
            default: for (int k = 0; k < n_ill; k++) sq.push_back(S_ILLEGAL);
        endcase
        for (int k = 0; k < sq.size(); k++)
            exp_q.push_back(rec(sq[k], fn, z, k == sq.size() - 1));
        wait_drain();
    endtask

    task automatic run_lat(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int want_lat);
        int r0;
        r0 = retire_cnt;
        run(op, fn, z, 1'b0, 0);
        chk({nm, "_latency"}, last_lat, want_lat);
        chk({nm, "_retires"}, retire_cnt - r0, 1);
    endtask

    initial begin
        int r0;
        opcode = 6'b100011;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'(dut_ov), 0);

        rst = 1'b1;
        r0 = retire_cnt;
        run(6'b100011, 6'd0, 1'b0, 1'b1, 0);
        chk("lw_latency", last_lat, 5);
        chk("lw_retires", retire_cnt - r0, 1);

        run_lat("sw",       6'b101011, 6'd0,      1'b0, 4);
        run_lat("beq_t",    6'b000100, 6'd0,      1'b1, 3);
        run_lat("beq_nt",   6'b000100, 6'd0,      1'b0, 3);
        run_lat("slt",      6'b000000, 6'b101010, 1'b0, 4);
        run_lat("add",      6'b000000, 6'b100000, 1'b0, 4);
        run_lat("sub",      6'b000000, 6'b100010, 1'b1, 4);
        run_lat("and",      6'b000000, 6'b100100, 1'b0, 4);
        run_lat("or",       6'b000000, 6'b100101, 1'b0, 4);
        run_lat("addi",     6'b001000, 6'd0,      1'b0, 4);
        run_lat("j",        6'b000010, 6'd0,      1'b0, 3);
        run_lat("multu",    6'b000000, 6'b011001, 1'b0, 3 + MULC);
        run_lat("mfhi",     6'b000000, 6'b010000, 1'b0, 3);
        run_lat("mflo",     6'b000000, 6'b010010, 1'b0, 3);
        run_lat("jal",      6'b000011, 6'd0,      1'b0, 3);
        run_lat("jr",       6'b000000, 6'b001000, 1'b0, 3);

        r0 = retire_cnt;
        run(6'b111111, 6'd0, 1'b0, 1'b0, 20);
        chk("illegal_still_set", int'(illegal), 1);
        chk("illegal_no_retire", retire_cnt - r0, 0);

        rst = 1'b0;
        #1;
        chk("reset_from_illegal", int'(dut_ov), 0);
        repeat (2) exp_q.push_back(rec(S_RESET, 6'd0, 1'b0, 1'b0));
        wait_drain();

        // Start a multu, then pull reset in the middle of its wait.
        rst = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b011001;
        exp_q.push_back(rec(S_RESET, funct, 1'b0, 1'b0));
        exp_q.push_back(rec(S_FETCH, funct, 1'b0, 1'b0));
        exp_q.push_back(rec(S_DECODE, funct, 1'b0, 1'b0));
        exp_q.push_back(rec(S_MULSTART, funct, 1'b0, 1'b0));
        exp_q.push_back(rec(S_MULWAIT, funct, 1'b0, 1'b0));
        exp_q.push_back(rec(S_MULWAIT, funct, 1'b0, 1'b0));
        wait_drain();
        chk("mid_wait_busy", int'(mul_busy), 1);
        rst = 1'b0;
        #1;
        chk("reset_mid_mulwait", int'(dut_ov), 0);
        repeat (3) exp_q.push_back(rec(S_RESET, 6'd0, 1'b0, 1'b0));
        wait_drain();

        rst = 1'b1;
        r0 = retire_cnt;
        run(6'b000000, 6'b010010, 1'b0, 1'b1, 0);
        chk("mflo_after_reset_latency", last_lat, 3);
        chk("mflo_after_reset_retires", retire_cnt - r0, 1);

        run(6'b000000, 6'b000001, 1'b0, 1'b0, 3);
        chk("bad_funct_illegal", int'(illegal), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle sequencing controller for the MIPS core, replacing single-cycle decode.
- Drives one shared memory port, IR/PC write enables, ALU operand muxes and register write, one state per step.
- Sequences MULTU over a fixed number of wait cycles, then MFHI/MFLO read back.
- Inputs: opcode/funct from the instruction register and the ALU zero flag.

Parameters:
MUL_CYCLES, 32, wait cycles after mul_start before MULTU retires (must be >=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
pc_we  output  1  PC write enable
iord  output  1  memory address select: 0=PC, 1=ALUOut
ir_we  output  1  instruction register write enable
we_dm  output  1  data memory write enable
reg_dst  output  1  0=rt, 1=rd
dm2reg  output  1  register write data: 1=memory data register
we_reg  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=rs
alu_src_b  output  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_ctrl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target, 11=rs
jal  output  1  write PC to $31
jr  output  1  PC from rs
mul_start  output  1  one-cycle start pulse to multiplier
mul_busy  output  1  high while waiting on multiplier
mf_hi_lo  output  1  register write data from HI/LO
hi_lo  output  1  1=HI, 0=LO
retire  output  1  one-cycle pulse in each instruction's final state
illegal  output  1  sticky unsupported-opcode/funct flag
state  output  5  current state encoding, for debug

Behaviour:
- State register and mul counter reset asynchronously on rst low to RESET; counter=0.
- Outputs are decoded from state (Moore), except pc_we in BRANCH, which is zero.
- Any output not listed for a state is 0.
- RESET: all outputs 0; next FETCH.
- FETCH: iord=0, ir_we=1, pc_we=1, alu_src_a=0, alu_src_b=01, alu_ctrl=010, pc_src=00; next DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=010 (branch target into ALUOut). Dispatch:
  - 100011 lw, 101011 sw -> MEMADR
  - 000100 beq -> BRANCH
  - 001000 addi -> ADDIEX
  - 000010 j -> JUMP
  - 000011 jal -> JAL
  - 000000 R-type: funct 001000 -> JR; 011001 -> MULSTART; 010000/010010 -> MFHL; 100000/100010/100100/100101/101010 -> EXEC; other funct -> ILLEGAL
  - any other opcode -> ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=010; next MEMRD if lw, MEMWR if sw.
- MEMRD: iord=1; next MEMWB.
- MEMWB: reg_dst=0, dm2reg=1, we_reg=1, retire; next FETCH.
- MEMWR: iord=1, we_dm=1, retire; next FETCH.
- EXEC: alu_src_a=1, alu_src_b=00; alu_ctrl from funct (100000->010, 100010->110, 100100->000, 100101->001, 101010->111); next ALUWB.
- ALUWB: reg_dst=1, we_reg=1, retire; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_src=01, pc_we=zero, retire; next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=010; next ADDIWB.
- ADDIWB: reg_dst=0, we_reg=1, retire; next FETCH.
- JUMP: pc_src=10, pc_we=1, retire; next FETCH.
- JAL: pc_src=10, pc_we=1, jal=1, we_reg=1, retire (writes PC+4 already held in PC); next FETCH.
- JR: pc_src=11, pc_we=1, jr=1, retire; next FETCH.
- MULSTART: mul_start=1, counter loads MUL_CYCLES-1; next MULWAIT.
- MULWAIT: mul_busy=1, counter decrements each cycle. At counter==0: retire, next FETCH. Exactly MUL_CYCLES cycles in MULWAIT.
- MFHL: mf_hi_lo=1, hi_lo=(funct==010000), reg_dst=1, we_reg=1, retire; next FETCH.
- ILLEGAL: illegal=1, all enables 0; stays until reset.
- Latencies in cycles:
  - lw 5; sw 4
  - R-type ALU 4; addi 4
  - beq, j, jal, jr, mfhi/mflo 3
  - multu 3+MUL_CYCLES
- Reset mid-instruction: immediate return to RESET, all enables 0. Counter cleared, no further mul_start.
- Opcode/funct must be stable from DECODE through the final state; IR is written only in FETCH.

Test Plan:
- Reset release, then opcode=100011 -> state sequence RESET,FETCH,DECODE,MEMADR,MEMRD,MEMWB; we_reg=1 and dm2reg=1 only in MEMWB; retire once.
- beq with zero=1, then with zero=0 -> BRANCH pc_we=1 / 0; pc_src=01, alu_ctrl=110 both times.
- R-type funct 101010 -> alu_ctrl=111 in EXEC; ALUWB reg_dst=1, we_reg=1; 4 cycles FETCH to retire.
- multu with MUL_CYCLES=4 -> mul_start high 1 cycle, mul_busy high 4 cycles, retire on 4th; next cycle FETCH. Then mfhi -> mf_hi_lo=1, hi_lo=1.
- jal then jr -> JAL: pc_src=10, jal=1, we_reg=1. JR: pc_src=11, jr=1, pc_we=1.
- opcode=111111 -> ILLEGAL, illegal=1 sticky, no enables for 20 cycles. Also drive rst low during MULWAIT -> immediate RESET, all outputs 0.
